// File: rtl/x_delay_line_pkg.sv
// x_delay_line_pkg: shared state encoding and default geometry for the delay-line readout
package x_delay_line_pkg;
    localparam int N_CELLS_DEF        = 64;
    localparam int SYNC_STAGES_DEF    = 2;
    localparam int RECOVER_CYCLES_DEF = 2;
    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE, S_SHIFT, S_RECOVER, S_DONE
    } state_t;
endpackage

// File: rtl/x_dl_therm_accum.sv
// x_dl_therm_accum: serial popcount of the captured line with thermometer bubble detection
module x_dl_therm_accum
    import x_delay_line_pkg::*;
#(
    parameter  int N_CELLS = N_CELLS_DEF,
    localparam int CNT_W   = $clog2(N_CELLS + 1)
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             clr_i,
    input  logic             sample_en_i,
    input  logic             bit_i,
    output logic [CNT_W-1:0] count_o,
    output logic             bubble_o
);
    logic [CNT_W-1:0] count_q;
    logic             seen_q, bubble_q;
    // Bits arrive farthest tap first, so a 0 after any 1 breaks the thermometer code
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            count_q  <= '0;
            seen_q   <= 1'b0;
            bubble_q <= 1'b0;
        end else if (clr_i) begin
            count_q  <= '0;
            seen_q   <= 1'b0;
            bubble_q <= 1'b0;
        end else if (sample_en_i) begin
            count_q  <= count_q + CNT_W'(bit_i);
            seen_q   <= seen_q | bit_i;
            bubble_q <= bubble_q | (seen_q & ~bit_i);
        end
    end
    assign count_o  = count_q;
    assign bubble_o = bubble_q;
endmodule

// File: rtl/x_delay_line_readout.sv
// x_delay_line_readout: launches an edge into the delay line, captures and shifts out the taps,
// and presents the decoded tap count on a valid/ready interface
module x_delay_line_readout
    import x_delay_line_pkg::*;
#(
    parameter  int N_CELLS        = N_CELLS_DEF,
    parameter  int SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter  int RECOVER_CYCLES = RECOVER_CYCLES_DEF,
    localparam int CNT_W          = $clog2(N_CELLS + 1)
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_launch,
    output logic             o_dl_en,
    output logic             o_shift_en,
    output logic             o_shift_in,
    input  logic             i_shift,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_count,
    output logic             o_bubble,
    output logic             o_overflow,
    output logic             o_underflow
);
    localparam int TW = $clog2(N_CELLS) + 1;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0] acc_count;
    logic             acc_bubble, clr, load;

    assign clr  = (state_q == S_IDLE) && i_start;
    assign load = (state_q == S_RECOVER) && (state_d == S_DONE);

    x_dl_therm_accum #(.N_CELLS(N_CELLS)) u_accum (
        .i_clk      (i_clk),
        .i_nrst     (i_nrst),
        .clr_i      (clr),
        .sample_en_i(state_q == S_SHIFT),
        .bit_i      (i_shift),
        .count_o    (acc_count),
        .bubble_o   (acc_bubble)
    );

    // One shared down-counter times WAIT, SHIFT and RECOVER; it holds length-1 on entry
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            S_IDLE:    state_d = i_start ? S_LAUNCH : S_IDLE;
            S_LAUNCH: begin
                state_d = S_WAIT;
                tmr_d   = TW'(SYNC_STAGES - 2);
            end
            S_WAIT: begin
                state_d = (tmr_q == '0) ? S_CAPTURE : S_WAIT;
                tmr_d   = tmr_q - 1'b1;
            end
            S_CAPTURE: begin
                state_d = S_SHIFT;
                tmr_d   = TW'(N_CELLS - 1);
            end
            S_SHIFT: begin
                state_d = (tmr_q == '0) ? S_RECOVER : S_SHIFT;
                tmr_d   = (tmr_q == '0) ? TW'(RECOVER_CYCLES - 1) : tmr_q - 1'b1;
            end
            S_RECOVER: begin
                state_d = (tmr_q == '0) ? S_DONE : S_RECOVER;
                tmr_d   = tmr_q - 1'b1;
            end
            S_DONE:    state_d = i_ready ? S_IDLE : S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with the state they describe
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            o_busy      <= 1'b0;
            o_launch    <= 1'b0;
            o_dl_en     <= 1'b0;
            o_shift_en  <= 1'b0;
            o_valid     <= 1'b0;
            o_count     <= '0;
            o_bubble    <= 1'b0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            o_busy     <= state_d != S_IDLE;
            o_launch   <= state_d inside {S_LAUNCH, S_WAIT, S_CAPTURE, S_SHIFT};
            o_dl_en    <= state_d == S_CAPTURE;
            o_shift_en <= state_d == S_SHIFT;
            o_valid    <= state_d == S_DONE;
            if (load) begin
                o_count     <= acc_count;
                o_bubble    <= acc_bubble;
                o_overflow  <= acc_count == CNT_W'(N_CELLS);
                o_underflow <= acc_count == '0;
            end
        end
    end

    assign o_shift_in = 1'b0;
endmodule

// File: tb/tb_x_delay_line_readout.sv
// tb_x_delay_line_readout: directed measurements against a timeline model of the readout
module tb_x_delay_line_readout;
    localparam int N    = 64;
    localparam int SS   = 2;
    localparam int RC   = 2;
    localparam int LAT  = 1 + SS + N + RC;
    localparam int LEND = 1 + SS + N;

    logic        clk = 1'b0;
    logic        i_nrst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_ready = 1'b0;
    logic        i_shift;
    logic        o_busy, o_launch, o_dl_en, o_shift_en, o_shift_in, o_valid;
    logic [6:0]  o_count;
    logic        o_bubble, o_overflow, o_underflow;
    logic [N-1:0] line_pat = '0;
    logic [N-1:0] chain = '0;
    logic        m_act = 1'b0;
    int          m_t = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    x_delay_line_readout dut (
        .i_clk(clk), .i_nrst(i_nrst), .i_start(i_start), .o_busy(o_busy),
        .o_launch(o_launch), .o_dl_en(o_dl_en), .o_shift_en(o_shift_en),
        .o_shift_in(o_shift_in), .i_shift(i_shift), .o_valid(o_valid),
        .i_ready(i_ready), .o_count(o_count), .o_bubble(o_bubble),
        .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    // Cell chain: captures the launched pattern, then shifts toward the far end
    always @(posedge clk) begin
        if (o_dl_en) chain <= o_launch ? line_pat : '0;
        else if (o_shift_en) chain <= {chain[N-2:0], o_shift_in};
    end
    assign i_shift = chain[N-1];

    // Timeline model: m_t counts edges since the accepting edge
    always @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            m_act <= 1'b0;
            m_t   <= 0;
        end else if (!m_act) begin
            if (i_start) begin
                m_act <= 1'b1;
                m_t   <= 0;
            end
        end else if (m_t >= LAT && i_ready) m_act <= 1'b0;
        else m_t <= m_t + 1;
    end

    function automatic logic exp_bubble(input logic [N-1:0] p);
        logic [N:0] m;
        m = ({{N{1'b0}}, 1'b1} << $countones(p)) - 1;
        return p != m[N-1:0];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!i_nrst) begin
            chk("rst_outs", {o_busy, o_launch, o_dl_en, o_shift_en, o_valid, o_count, o_bubble, o_overflow, o_underflow}, 0);
        end else begin
            chk("busy", o_busy, m_act);
            chk("launch", o_launch, m_act && m_t < LEND);
            chk("dl_en", o_dl_en, m_act && m_t == SS);
            chk("shift_en", o_shift_en, m_act && m_t > SS && m_t <= SS + N);
            chk("valid", o_valid, m_act && m_t >= LAT);
            chk("shift_in", o_shift_in, 0);
            if (m_act && m_t >= LAT) begin
                chk("count", o_count, $countones(line_pat));
                chk("bubble", o_bubble, exp_bubble(line_pat));
                chk("overflow", o_overflow, $countones(line_pat) == N);
                chk("underflow", o_underflow, $countones(line_pat) == 0);
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic meas(input logic [N-1:0] p, input int ec, input logic eb, input logic eo,
                        input logic eu, input int rdly, input logic poke);
        int n;
        line_pat = p;
        nxt();
        i_start = 1'b1;
        nxt();
        i_start = 1'b0;
        n = 1;
        while (!o_valid && n < 200) begin
            nxt();
            n++;
            i_start = poke && n == 20;
        end
        i_start = 1'b0;
        chk("latency", n - 1, 69);
        chk("lit_count", o_count, ec);
        chk("lit_bubble", o_bubble, eb);
        chk("lit_overflow", o_overflow, eo);
        chk("lit_underflow", o_underflow, eu);
        repeat (rdly) begin
            nxt();
            i_start = poke;
        end
        i_start = 1'b0;
        chk("hold_valid", o_valid, 1);
        chk("hold_count", o_count, ec);
        i_ready = 1'b1;
        nxt();
        i_ready = 1'b0;
        chk("hs_valid", o_valid, 0);
        chk("hs_busy", o_busy, 0);
    endtask

    initial begin
        #1 i_nrst = 1'b0;
        repeat (3) nxt();
        i_nrst = 1'b1;
        nxt();
        meas(64'hF_FFFF, 20, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        meas({N{1'b1}}, 64, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        meas('0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        meas(64'b1011, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        meas(64'hF_FFFF, 20, 1'b0, 1'b0, 1'b0, 10, 1'b1);
        meas(64'h1F, 5, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        line_pat = 64'hFFF;
        nxt();
        i_start = 1'b1;
        nxt();
        i_start = 1'b0;
        repeat (32) nxt();
        chk("pre_rst_shift", o_shift_en, 1);
        i_nrst = 1'b0;
        #1;
        chk("rst_mid", {o_busy, o_launch, o_dl_en, o_shift_en, o_valid, o_count, o_bubble, o_overflow, o_underflow}, 0);
        nxt();
        i_nrst = 1'b1;
        nxt();
        meas(64'h1FF_FFFF_FFFF, 41, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        repeat (3) nxt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
